// File: rtl/dif_pair_buffer_pkg.sv
// dif_pair_buffer shared definitions.
// Stage-length and address-width helpers also used by the butterfly's twiddle addressing.
package dif_pair_buffer_pkg;

   localparam int DEF_IN_W   = 10;
   localparam int DEF_STAGES = 8;

   // MSB of the sample counter: which half of the frame is arriving
   typedef enum logic {
      FILL = 1'b0,
      PAIR = 1'b1
   } half_e;

   function automatic int stage_len(
      input int total,
      input int stage
   );
      return 1 << (total - stage);
   endfunction

   function automatic int addr_w(input int depth);
      return (depth <= 1) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/dif_pair_buffer_if.sv
// Serial sample input and paired-sample output bundle.
// Output signal names match the butterfly's inputs one-to-one.
interface dif_pair_buffer_if #(
   parameter int IN_W = 10
);

   logic                   i_vld;
   logic                   i_sof;
   logic signed [IN_W-1:0] i_I;
   logic signed [IN_W-1:0] i_Q;

   logic                   o_vld;
   logic                   o_sof;
   logic                   o_misalign_strb;
   logic signed [IN_W-1:0] o_LI;
   logic signed [IN_W-1:0] o_LQ;
   logic signed [IN_W-1:0] o_RI;
   logic signed [IN_W-1:0] o_RQ;

   modport master (
      output i_vld,
      output i_sof,
      output i_I,
      output i_Q,
      input  o_vld,
      input  o_sof,
      input  o_misalign_strb,
      input  o_LI,
      input  o_LQ,
      input  o_RI,
      input  o_RQ
   );

   modport slave (
      input  i_vld,
      input  i_sof,
      input  i_I,
      input  i_Q,
      output o_vld,
      output o_sof,
      output o_misalign_strb,
      output o_LI,
      output o_LQ,
      output o_RI,
      output o_RQ
   );

endinterface

// File: rtl/dif_pair_buffer_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Contents are never reset; readers only see locations written earlier.
module sdp_ram #(
   parameter int W     = 20,
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/dif_pair_buffer.sv
// DIF stage input buffer: stores the first half of a frame and
// pairs x[k] with x[k+HALF] as the second half streams in.
module dif_pair_buffer
   import dif_pair_buffer_pkg::*;
#(
   parameter int IN_W         = DEF_IN_W,
   parameter int STAGE        = 0,
   parameter int TOTAL_STAGES = DEF_STAGES
) (
   input  logic               mclk,
   input  logic               i_init,
   dif_pair_buffer_if.slave   bus
);

   localparam int STAGE_FFT_LEN = stage_len(TOTAL_STAGES, STAGE);
   localparam int HALF          = STAGE_FFT_LEN / 2;
   localparam int CW            = TOTAL_STAGES - STAGE;
   localparam int AW            = addr_w(HALF);
   localparam int DW            = 2 * IN_W;

   logic [CW-1:0]          cnt;
   logic [CW-1:0]          cnt_nxt;
   logic [CW-1:0]          eff;
   logic                   acc;
   logic                   misalign;
   half_e                  phase;
   logic [AW-1:0]          k;
   logic                   we;
   logic                   re;
   logic [DW-1:0]          rdata;
   logic                   v1;
   logic                   sof1;
   logic signed [IN_W-1:0] cur_i;
   logic signed [IN_W-1:0] cur_q;

   assign acc      = bus.i_vld & ~i_init;
   assign misalign = acc & bus.i_sof & (cnt != '0);

   // A misaligned sof restarts the frame: the sample becomes index 0
   always_comb begin
      eff     = cnt;
      cnt_nxt = cnt;
      unique case (1'b1)
         !acc: begin
            cnt_nxt = cnt;
         end
         misalign: begin
            eff     = '0;
            cnt_nxt = CW'(1);
         end
         default: begin
            cnt_nxt = cnt + CW'(1);
         end
      endcase
   end

   assign phase = half_e'(eff[CW-1]);

   if (CW == 1) begin : g_one
      assign k = '0;
   end else begin : g_many
      assign k = eff[AW-1:0];
   end

   assign we = acc & (phase == FILL);
   assign re = acc & (phase == PAIR);

   sdp_ram #(
      .W     (DW),
      .DEPTH (HALF),
      .AW    (AW)
   ) u_ram (
      .clk   (mclk),
      .we    (we),
      .waddr (k),
      .wdata ({bus.i_I, bus.i_Q}),
      .re    (re),
      .raddr (k),
      .rdata (rdata)
   );

   // Current sample delayed to line up with the registered RAM read
   always_ff @(posedge mclk) begin
      if (re) begin
         cur_i <= bus.i_I;
         cur_q <= bus.i_Q;
      end
   end

   always_ff @(posedge mclk) begin
      if (i_init) begin
         cnt                 <= '0;
         v1                  <= 1'b0;
         sof1                <= 1'b0;
         bus.o_vld           <= 1'b0;
         bus.o_sof           <= 1'b0;
         bus.o_misalign_strb <= 1'b0;
         bus.o_LI            <= '0;
         bus.o_LQ            <= '0;
         bus.o_RI            <= '0;
         bus.o_RQ            <= '0;
      end else begin
         cnt                 <= cnt_nxt;
         v1                  <= re;
         sof1                <= re & (k == '0);
         bus.o_misalign_strb <= misalign;
         bus.o_vld           <= v1;
         bus.o_sof           <= v1 & sof1;
         if (v1) begin
            bus.o_LI <= rdata[DW-1:IN_W];
            bus.o_LQ <= rdata[IN_W-1:0];
            bus.o_RI <= cur_i;
            bus.o_RQ <= cur_q;
         end
      end
   end

endmodule

// File: tb/tb_dif_pair_buffer.sv
// Scoreboard bench for dif_pair_buffer: N=8 and N=2 instances
// driven by directed frames then random traffic.
module tb_dif_pair_buffer;

   localparam int W = 10;

   typedef struct {
      int     li;
      int     lq;
      int     ri;
      int     rq;
      bit     sof;
      longint due;
   } pair_t;

   logic   mclk = 1'b0;
   logic   init = 1'b1;
   longint cyc  = 0;
   int     total = 0;
   int     bad   = 0;

   pair_t  expq  [2][$];
   longint strbq [2][$];
   int     fi    [2][$];
   int     fq    [2][$];
   int     nlen  [2] = '{8, 2};

   bit     dv [2];
   bit     ds [2];
   int     di [2];
   int     dq [2];
   bit     dinit;

   always #5 mclk = ~mclk;

   always @(posedge mclk) cyc <= cyc + 1;

   dif_pair_buffer_if #(.IN_W(W)) b8 ();
   dif_pair_buffer_if #(.IN_W(W)) b2 ();

   dif_pair_buffer #(
      .IN_W         (W),
      .STAGE        (0),
      .TOTAL_STAGES (3)
   ) u8 (
      .mclk   (mclk),
      .i_init (init),
      .bus    (b8)
   );

   dif_pair_buffer #(
      .IN_W         (W),
      .STAGE        (0),
      .TOTAL_STAGES (1)
   ) u2 (
      .mclk   (mclk),
      .i_init (init),
      .bus    (b2)
   );

   task automatic check(string nm, bit ok, string act, string exp);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s: got %s, want %s", nm, act, exp);
      end
   endtask

   function automatic int sx(int v);
      int r;
      r = v & 1023;
      if (r >= 512) r -= 1024;
      return r;
   endfunction

   // Reference: a frame is a list of accepted samples; entry j>=HALF pairs with j-HALF
   task automatic accept(int d, bit s, int smp_i, int smp_q, longint c);
      pair_t p;
      int    h;
      int    idx;
      h = nlen[d] / 2;
      if (s && fi[d].size() != 0) begin
         fi[d].delete();
         fq[d].delete();
         strbq[d].push_back(c + 1);
      end
      fi[d].push_back(smp_i);
      fq[d].push_back(smp_q);
      idx = fi[d].size() - 1;
      if (idx >= h) begin
         p.li  = fi[d][idx-h];
         p.lq  = fq[d][idx-h];
         p.ri  = smp_i;
         p.rq  = smp_q;
         p.sof = (idx == h);
         p.due = c + 2;
         expq[d].push_back(p);
      end
      if (fi[d].size() == nlen[d]) begin
         fi[d].delete();
         fq[d].delete();
      end
   endtask

   task automatic tick();
      longint c;
      c = cyc;
      init     = dinit;
      b8.i_vld = dv[0];
      b8.i_sof = ds[0];
      b8.i_I   = W'(di[0]);
      b8.i_Q   = W'(dq[0]);
      b2.i_vld = dv[1];
      b2.i_sof = ds[1];
      b2.i_I   = W'(di[1]);
      b2.i_Q   = W'(dq[1]);
      for (int d = 0; d < 2; d++) begin
         if (dinit) begin
            fi[d].delete();
            fq[d].delete();
            while (expq[d].size() > 0 && expq[d][$].due > c)
               void'(expq[d].pop_back());
            while (strbq[d].size() > 0 && strbq[d][$] > c)
               void'(strbq[d].pop_back());
         end else if (dv[d]) begin
            accept(d, ds[d], di[d], dq[d], c);
         end
      end
      @(posedge mclk);
      #1;
      dv    = '{1'b0, 1'b0};
      ds    = '{1'b0, 1'b0};
      dinit = 1'b0;
   endtask

   task automatic send(int d, bit s, int smp_i, int smp_q, int gap);
      dv[d] = 1'b1;
      ds[d] = s;
      di[d] = smp_i;
      dq[d] = smp_q;
      tick();
      repeat (gap) tick();
   endtask

   task automatic zero_check(string nm, bit vld, bit sof, bit strb,
                             int li, int lq, int ri, int rq);
      bit ok;
      ok = !vld && !sof && !strb && li == 0 && lq == 0 && ri == 0 && rq == 0;
      check(nm, ok,
            $sformatf("vld=%0d sof=%0d strb=%0d L=(%0d,%0d) R=(%0d,%0d)",
                      vld, sof, strb, li, lq, ri, rq),
            "all zero");
   endtask

   task automatic reset_check(string nm);
      @(negedge mclk);
      zero_check({nm, "_n8"}, b8.o_vld, b8.o_sof, b8.o_misalign_strb,
                 int'(b8.o_LI), int'(b8.o_LQ), int'(b8.o_RI), int'(b8.o_RQ));
      zero_check({nm, "_n2"}, b2.o_vld, b2.o_sof, b2.o_misalign_strb,
                 int'(b2.o_LI), int'(b2.o_LQ), int'(b2.o_RI), int'(b2.o_RQ));
      @(posedge mclk);
      #1;
   endtask

   task automatic mon(int d, bit vld, bit sof, bit strb,
                      int li, int lq, int ri, int rq);
      pair_t  p;
      longint s;
      bit     ok;
      while (expq[d].size() > 0 && expq[d][0].due < cyc) begin
         p = expq[d].pop_front();
         check($sformatf("missing_pair%0d", d), 1'b0,
               $sformatf("no o_vld at cyc %0d", p.due),
               $sformatf("L=(%0d,%0d) R=(%0d,%0d)", p.li, p.lq, p.ri, p.rq));
      end
      if (vld) begin
         if (expq[d].size() == 0) begin
            check($sformatf("extra_pair%0d", d), 1'b0,
                  $sformatf("L=(%0d,%0d) R=(%0d,%0d) cyc=%0d", li, lq, ri, rq, cyc),
                  "no pair");
         end else begin
            p  = expq[d].pop_front();
            ok = li == p.li && lq == p.lq && ri == p.ri && rq == p.rq &&
                 sof == p.sof && cyc == p.due;
            check($sformatf("pair%0d", d), ok,
                  $sformatf("L=(%0d,%0d) R=(%0d,%0d) sof=%0d cyc=%0d",
                            li, lq, ri, rq, sof, cyc),
                  $sformatf("L=(%0d,%0d) R=(%0d,%0d) sof=%0d cyc=%0d",
                            p.li, p.lq, p.ri, p.rq, p.sof, p.due));
         end
      end
      while (strbq[d].size() > 0 && strbq[d][0] < cyc) begin
         s = strbq[d].pop_front();
         check($sformatf("missing_strb%0d", d), 1'b0, "no pulse",
               $sformatf("pulse at cyc %0d", s));
      end
      if (strb) begin
         if (strbq[d].size() == 0) begin
            check($sformatf("extra_strb%0d", d), 1'b0,
                  $sformatf("pulse at cyc %0d", cyc), "no pulse");
         end else begin
            s = strbq[d].pop_front();
            check($sformatf("strb%0d", d), cyc == s,
                  $sformatf("cyc %0d", cyc), $sformatf("cyc %0d", s));
         end
      end
   endtask

   always @(negedge mclk) begin
      mon(0, b8.o_vld, b8.o_sof, b8.o_misalign_strb,
          int'(b8.o_LI), int'(b8.o_LQ), int'(b8.o_RI), int'(b8.o_RQ));
      mon(1, b2.o_vld, b2.o_sof, b2.o_misalign_strb,
          int'(b2.o_LI), int'(b2.o_LQ), int'(b2.o_RI), int'(b2.o_RQ));
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not end, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int smp_i;
      int smp_q;
      dv    = '{1'b0, 1'b0};
      ds    = '{1'b0, 1'b0};
      di    = '{0, 0};
      dq    = '{0, 0};
      dinit = 1'b1;
      @(posedge mclk);
      #1;
      // samples offered during reset must be ignored
      dv    = '{1'b1, 1'b1};
      ds    = '{1'b0, 1'b1};
      di    = '{33, 44};
      dq    = '{-33, -44};
      dinit = 1'b1;
      tick();
      dinit = 1'b1;
      tick();
      reset_check("reset");

      for (int k = 0; k < 8; k++) send(0, k == 0, k, -k, 0);
      repeat (4) tick();

      for (int k = 0; k < 8; k++) send(0, k == 0, k, -k, $urandom_range(0, 3));
      repeat (4) tick();

      for (int v = 0; v < 24; v++) begin
         smp_i = v;
         smp_q = -v;
         if (v == 16) begin smp_i = -512; smp_q = 511; end
         if (v == 20) begin smp_i = 511; smp_q = -512; end
         send(0, v % 8 == 0, smp_i, smp_q, 0);
      end
      repeat (4) tick();

      for (int k = 0; k < 6; k++) send(0, k == 0, 50 + k, k, 0);
      dinit = 1'b1;
      tick();
      reset_check("midreset");
      for (int k = 0; k < 8; k++) send(0, k == 0, 100 + k, -100 - k, 0);
      repeat (4) tick();

      send(0, 1'b1, 1, 1, 0);
      send(0, 1'b0, 2, 2, 0);
      for (int k = 0; k < 8; k++) send(0, k == 0, 200 + k, -200 - k, 0);
      repeat (4) tick();

      send(1, 1'b1, 7, 70, 0);
      send(1, 1'b0, -3, -30, 0);
      send(1, 1'b1, 5, 50, 0);
      send(1, 1'b0, 9, 90, 0);
      repeat (4) tick();

      for (int n = 0; n < 2000; n++) begin
         for (int d = 0; d < 2; d++) begin
            dv[d] = $urandom_range(0, 3) != 0;
            ds[d] = $urandom_range(0, 9) == 0;
            di[d] = sx(int'($urandom_range(0, 1023)));
            dq[d] = sx(int'($urandom_range(0, 1023)));
         end
         dinit = $urandom_range(0, 99) == 0;
         tick();
      end
      repeat (6) tick();

      for (int d = 0; d < 2; d++) begin
         check($sformatf("drain_pairs%0d", d), expq[d].size() == 0,
               $sformatf("%0d pending", expq[d].size()), "0 pending");
         check($sformatf("drain_strb%0d", d), strbq[d].size() == 0,
               $sformatf("%0d pending", strbq[d].size()), "0 pending");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
